// File: rtl/alu_pkg.sv
// Shared definitions for the small arithmetic units: FSM state encoding and
// the opcode values carried on the subtract select.
package alu_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : alu_pkg

// File: rtl/bit_full_adder.sv
// Single-bit structural full adder; the entire combinational datapath of the
// bit-serial adder/subtractor.
module bit_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic a_x_b;

    assign a_x_b = a ^ b;
    assign sum   = a_x_b ^ cin;
    assign cout  = (a & b) | (cin & a_x_b);

endmodule : bit_full_adder

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor: one bit per clock, LSB first,
// through a single full-adder cell, with a start/done handshake.
module serial_add_sub
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q,  state_d;
    logic [WIDTH-1:0]   sa_q,     sa_d;
    logic [WIDTH-1:0]   sb_q,     sb_d;
    logic [WIDTH-1:0]   sr_q,     sr_d;
    logic               c_q,      c_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               co_q,     co_d;
    logic               ovf_q,    ovf_d;
    logic               zero_q,   zero_d;

    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   sr_next;

    bit_full_adder u_fa (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .cin  (c_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign sr_next = {fa_sum, sr_q[WIDTH-1:1]};

    always_comb begin
        // NOTE: every next-state signal takes its held value first, so no path through this block can infer a latch.
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sr_d     = sr_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        co_d     = co_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
                    state_d = RUN;
                    sa_d    = a;
                    sb_d    = (subtract == OP_SUB) ? ~b : b;
                    c_d     = subtract;
                    cnt_d   = '0;
                    sr_d    = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                sr_d  = sr_next;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                c_d   = fa_cout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // Overflow is the carry into the sign bit disagreeing with the carry out of it.
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = sr_next;
                    co_d     = fa_cout;
                    ovf_d    = c_q ^ fa_cout;
                    zero_d   = (sr_next == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sr_q     <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            co_q     <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from values sampled before the edge.
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sr_q     <= sr_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            co_q     <= co_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign carryout = co_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule : serial_add_sub

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub at WIDTH=8: a driver pushes expected
// results from an arithmetic model, a monitor pops them on every done pulse.
module tb_serial_add_sub;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        logic         z;
        int unsigned  done_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         subtract;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carryout;
    logic         overflow;
    logic         zero;

    int unsigned  cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    exp_t         sb_q[$];
    exp_t         prev;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .subtract (subtract),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carryout (carryout),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
        exp_t        e;
        int unsigned ux = x;
        int unsigned uy = y;
        int          sx = int'($signed(x));
        int          sy = int'($signed(y));
        int          s_full;
        if (sub) begin
            e.res  = W'(ux - uy);
            e.co   = (ux >= uy);
            s_full = sx - sy;
        end else begin
            e.res  = W'(ux + uy);
            e.co   = ((ux + uy) >= (1 << W));
            s_full = sx + sy;
        end
        e.ov       = (s_full > (1 << (W - 1)) - 1) || (s_full < -(1 << (W - 1)));
        e.z        = (e.res == '0);
        e.done_cyc = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done && busy) check("done_with_busy", 1, 0);
        if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("done_latency", 64'(cyc), 64'(e.done_cyc));
                check("result",   result,   e.res);
                check("carryout", carryout, e.co);
                check("overflow", overflow, e.ov);
                check("zero",     zero,     e.z);
            end
        end
    end

    // Entered at a negedge where the DUT is idle or presenting done; returns
    // at the negedge where this operation's done is visible.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub, input logic noisy);
        exp_t e;
        start    = 1'b1;
        a        = x;
        b        = y;
        subtract = sub;
        @(negedge clk);
        e          = model(x, y, sub);
        e.done_cyc = cyc + W;
        check("hold_result", result,   prev.res);
        check("hold_flags",  {carryout, overflow, zero}, {prev.co, prev.ov, prev.z});
        sb_q.push_back(e);
        prev = e;
        for (int i = 0; i < W; i++) begin
            check("busy", busy, 1);
            start    = (i < W - 1) ? noisy : 1'b0;
            a        = W'($urandom);
            b        = W'($urandom);
            subtract = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h7F;
            3:       return 8'h80;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        subtract = 1'b0;
        a        = '0;
        b        = '0;
        prev     = '{res: '0, co: 1'b0, ov: 1'b0, z: 1'b0, done_cyc: 0};
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, result, carryout, overflow, zero}, '0);
        reset = 1'b0;
        idle(2);

        do_op(8'h05, 8'h03, 1'b0, 1'b0);
        idle(1);
        do_op(8'h10, 8'h10, 1'b1, 1'b0);
        idle(2);
        do_op(8'h03, 8'h05, 1'b1, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        idle(1);

        // Start held high with random operands throughout; must be ignored.
        do_op(8'h05, 8'h03, 1'b0, 1'b1);
        do_op(8'h80, 8'h01, 1'b1, 1'b1);
        idle(3);

        // Abort in the fourth RUN cycle; the reset must swallow the done pulse.
        start    = 1'b1;
        a        = 8'h55;
        b        = 8'h22;
        subtract = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_outputs", {busy, done, result, carryout, overflow, zero}, '0);
        prev = '{res: '0, co: 1'b0, ov: 1'b0, z: 1'b0, done_cyc: 0};
        idle(W + 2);
        do_op(8'h12, 8'h34, 1'b0, 1'b0);
        idle(1);

        for (int n = 0; n < 150; n++) begin
            do_op(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom));
            idle($urandom_range(0, 2));
        end

        idle(W + 4);
        check("pending_ops", 64'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_serial_add_sub
